// File: rtl/rgb888_to_ycbcr444_pkg.sv
// Shared constants for the RGB888 -> YCbCr 4:4:4 converter: fixed 8-bit
// fractional weights, chroma offset and pipeline depth.
package ycbcr_pkg;

  localparam int unsigned PIPE_DEPTH = 3;

  localparam logic [7:0] K_Y_R  = 8'd77;
  localparam logic [7:0] K_Y_G  = 8'd150;
  localparam logic [7:0] K_Y_B  = 8'd29;
  localparam logic [7:0] K_CB_R = 8'd43;
  localparam logic [7:0] K_CB_G = 8'd85;
  localparam logic [7:0] K_CB_B = 8'd128;
  localparam logic [7:0] K_CR_R = 8'd128;
  localparam logic [7:0] K_CR_G = 8'd107;
  localparam logic [7:0] K_CR_B = 8'd21;

  localparam logic [15:0] CHROMA_OFS = 16'd32768;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // 8x8 unsigned product; 255*150 is the largest and still fits 16 bits
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] k);
    return 16'(a) * 16'(k);
  endfunction

endpackage

// File: rtl/rgb888_to_ycbcr444_if.sv
// Pixel-stream bundle: frame sync plus RGB in, frame sync plus YCbCr out.
interface rgb888_to_ycbcr444_if;

  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;

  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_Y;
  logic [7:0] post_img_Cb;
  logic [7:0] post_img_Cr;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_red, per_img_green, per_img_blue,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_Y, post_img_Cb, post_img_Cr
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  per_img_red, per_img_green, per_img_blue,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_Y, post_img_Cb, post_img_Cr
  );

endinterface

// File: rtl/rgb888_to_ycbcr444_sync_delay.sv
// Generic fixed-depth shift register used to keep frame sync aligned with
// the pixel pipeline.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shift_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shift_q[i] <= '0;
    end else begin
      shift_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) shift_q[i] <= shift_q[i-1];
    end
  end

  assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/rgb888_to_ycbcr444.sv
// RGB888 -> YCbCr 4:4:4 converter, one pixel per clock, fixed 3-cycle latency.
// Datapath is free-running; outputs are forced to 0 outside the active line.
module rgb888_to_ycbcr444
  import ycbcr_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  rgb888_to_ycbcr444_if.slave        bus
);

  // Truncating fixed-point scale-back: the result is the upper byte of the sum
  function automatic logic [7:0] trunc_hi(input logic [15:0] sum);
    return sum[15:8];
  endfunction

  logic [15:0] prd_p1_d [9];
  logic [15:0] prd_p1_q [9];
  logic [15:0] y_sum_p2_d,  cb_sum_p2_d,  cr_sum_p2_d;
  logic [15:0] y_sum_p2_q,  cb_sum_p2_q,  cr_sum_p2_q;
  logic [7:0]  y_p3_q,      cb_p3_q,      cr_p3_q;
  sync_t       sync_in,     sync_out;

  always_comb begin
    prd_p1_d[0] = mul8(bus.per_img_red,   K_Y_R);
    prd_p1_d[1] = mul8(bus.per_img_green, K_Y_G);
    prd_p1_d[2] = mul8(bus.per_img_blue,  K_Y_B);
    prd_p1_d[3] = mul8(bus.per_img_red,   K_CB_R);
    prd_p1_d[4] = mul8(bus.per_img_green, K_CB_G);
    prd_p1_d[5] = mul8(bus.per_img_blue,  K_CB_B);
    prd_p1_d[6] = mul8(bus.per_img_red,   K_CR_R);
    prd_p1_d[7] = mul8(bus.per_img_green, K_CR_G);
    prd_p1_d[8] = mul8(bus.per_img_blue,  K_CR_B);
  end

  // Stage 1: nine products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prd_p1_q[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prd_p1_q[i] <= prd_p1_d[i];
    end
  end

  // Positive term and offset are added first so the 16-bit chroma sums never dip below zero
  always_comb begin
    y_sum_p2_d  = prd_p1_q[0] + prd_p1_q[1] + prd_p1_q[2];
    cb_sum_p2_d = ((prd_p1_q[5] + CHROMA_OFS) - prd_p1_q[3]) - prd_p1_q[4];
    cr_sum_p2_d = ((prd_p1_q[6] + CHROMA_OFS) - prd_p1_q[7]) - prd_p1_q[8];
  end

  // Stage 2: three 16-bit sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sum_p2_q  <= '0;
      cb_sum_p2_q <= '0;
      cr_sum_p2_q <= '0;
    end else begin
      y_sum_p2_q  <= y_sum_p2_d;
      cb_sum_p2_q <= cb_sum_p2_d;
      cr_sum_p2_q <= cr_sum_p2_d;
    end
  end

  // Stage 3: scaled 8-bit results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p3_q  <= '0;
      cb_p3_q <= '0;
      cr_p3_q <= '0;
    end else begin
      y_p3_q  <= trunc_hi(y_sum_p2_q);
      cb_p3_q <= trunc_hi(cb_sum_p2_q);
      cr_p3_q <= trunc_hi(cr_sum_p2_q);
    end
  end

  assign sync_in = '{vsync: bus.per_frame_vsync,
                     href:  bus.per_frame_href,
                     clken: bus.per_frame_clken};

  sync_delay #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (PIPE_DEPTH)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_in),
    .q_o   (sync_out)
  );

  assign bus.post_frame_vsync = sync_out.vsync;
  assign bus.post_frame_href  = sync_out.href;
  assign bus.post_frame_clken = sync_out.clken;
  assign bus.post_img_Y       = sync_out.href ? y_p3_q  : 8'd0;
  assign bus.post_img_Cb      = sync_out.href ? cb_p3_q : 8'd0;
  assign bus.post_img_Cr      = sync_out.href ? cr_p3_q : 8'd0;

endmodule

// File: tb/tb_rgb888_to_ycbcr444.sv
// Bench for rgb888_to_ycbcr444: directed colours, latency, gating, reset,
// and randomized streams against a delayed-formula reference model.
module tb_rgb888_to_ycbcr444;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb888_to_ycbcr444_if vif ();

  rgb888_to_ycbcr444 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pixels go in a 3-entry history; the output is the
  // textbook formula applied to the oldest entry.
  typedef struct {
    int vs, hr, ce, r, g, b;
  } px_t;

  px_t hist[$];

  function automatic px_t zero_px();
    px_t p;
    p.vs = 0; p.hr = 0; p.ce = 0; p.r = 0; p.g = 0; p.b = 0;
    return p;
  endfunction

  function automatic int f_y(px_t p);
    return (77*p.r + 150*p.g + 29*p.b) / 256;
  endfunction
  function automatic int f_cb(px_t p);
    return (128*p.b - 43*p.r - 85*p.g + 32768) / 256;
  endfunction
  function automatic int f_cr(px_t p);
    return (128*p.r - 107*p.g - 21*p.b + 32768) / 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || hist.size() != 3) begin
      hist = {};
      repeat (3) hist.push_back(zero_px());
    end else begin
      px_t p;
      p.vs = int'(vif.per_frame_vsync);
      p.hr = int'(vif.per_frame_href);
      p.ce = int'(vif.per_frame_clken);
      p.r  = int'(vif.per_img_red);
      p.g  = int'(vif.per_img_green);
      p.b  = int'(vif.per_img_blue);
      hist.push_back(p);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en && hist.size() == 3) begin
      px_t e;
      e = hist[0];
      chk("m_vsync", int'(vif.post_frame_vsync), e.vs);
      chk("m_href",  int'(vif.post_frame_href),  e.hr);
      chk("m_clken", int'(vif.post_frame_clken), e.ce);
      chk("m_Y",  int'(vif.post_img_Y),  (e.hr != 0) ? f_y(e)  : 0);
      chk("m_Cb", int'(vif.post_img_Cb), (e.hr != 0) ? f_cb(e) : 0);
      chk("m_Cr", int'(vif.post_img_Cr), (e.hr != 0) ? f_cr(e) : 0);
    end
  end

  // Length of the most recently completed post_frame_href pulse
  int run_len  = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (vif.post_frame_href) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic drive(input bit vs, input bit hr, input bit ce,
                       input int r, input int g, input int b);
    @(posedge clk);
    #1;
    vif.per_frame_vsync = vs;
    vif.per_frame_href  = hr;
    vif.per_frame_clken = ce;
    vif.per_img_red     = 8'(r);
    vif.per_img_green   = 8'(g);
    vif.per_img_blue    = 8'(b);
  endtask

  task automatic directed(input string tag, input int r, input int g, input int b,
                          input int ey, input int ecb, input int ecr);
    drive(1'b0, 1'b1, 1'b1, r, g, b);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_Y"},  int'(vif.post_img_Y),  ey);
    chk({tag, "_Cb"}, int'(vif.post_img_Cb), ecb);
    chk({tag, "_Cr"}, int'(vif.post_img_Cr), ecr);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Edges from the input change until the selected output follows (bounded)
  task automatic latency(input string tag, input int sel);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      seen = (sel == 0) ? vif.post_frame_vsync : vif.post_frame_href;
    end
    chk(tag, seen ? n : -1, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.per_frame_vsync = 1'b0;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_clken = 1'b0;
    vif.per_img_red     = 8'd0;
    vif.per_img_green   = 8'd0;
    vif.per_img_blue    = 8'd0;

    // Reset state, with nonzero inputs present
    repeat (2) @(posedge clk);
    #1;
    vif.per_frame_href = 1'b1;
    vif.per_img_red    = 8'd200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_href", int'(vif.post_frame_href), 0);
    chk("rst_Y",    int'(vif.post_img_Y), 0);
    chk("rst_Cb",   int'(vif.post_img_Cb), 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);

    directed("white", 255, 255, 255, 255, 128, 128);
    directed("black", 0, 0, 0, 0, 128, 128);
    directed("red",   255, 0, 0, 76, 85, 255);
    directed("green", 0, 255, 0, 149, 43, 21);
    directed("blue",  0, 0, 255, 28, 255, 107);

    // Gating: href low with nonzero RGB
    drive(1'b0, 1'b0, 1'b1, 200, 100, 50);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gate_Y",  int'(vif.post_img_Y), 0);
    chk("gate_Cb", int'(vif.post_img_Cb), 0);
    chk("gate_Cr", int'(vif.post_img_Cr), 0);

    // Vsync passes through 3 clk later
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
    latency("vsync_lat", 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    repeat (4) @(posedge clk);

    // 1280-pixel line with an incrementing pattern
    for (int i = 0; i < 1280; i++)
      drive(1'b0, 1'b1, 1'b1, i & 255, (i >> 2) & 255, 255 - (i & 255));
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("href_run", last_run, 1280);

    // Randomized stream, including isolated pixels and gaps
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 1'b1, 255, $urandom_range(0, 255), 0);
    @(posedge clk);
    #3;
    chk("pre_rst_href", int'(vif.post_frame_href), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_href",  int'(vif.post_frame_href), 0);
    chk("arst_vsync", int'(vif.post_frame_vsync), 0);
    chk("arst_clken", int'(vif.post_frame_clken), 0);
    chk("arst_Y",     int'(vif.post_img_Y), 0);
    chk("arst_Cr",    int'(vif.post_img_Cr), 0);
    repeat (3) @(posedge clk);
    #1;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_vsync = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b1, 1'b1, 255, 0, 0);
    latency("rst_href_lat", 1);
    @(negedge clk);
    chk("post_rst_Cr", int'(vif.post_img_Cr), 255);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 1'b1, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
